distance_median_filter: RTL and testbench
=========================================

# distance_median_filter

Downstream consumer of the reflectivity-corrected distance stage. Takes each corrected point (`ad_en`, `ad_distance`, `time_pluse_a`), gates it against range and pulse-width limits, and applies a 3-tap median across angularly adjacent points within one scan frame. It emits one filtered point per input point, delayed by one point. Output feeds the scan-frame packer.

## Interface
Parameters:
- `DW`, 16: distance width.
- `PW`, 12: pulse-width width.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: reset, asynchronous and active-low.
- `ad_en`, in, 1: one-cycle strobe; the corrected point is valid.
- `ad_distance`, in, DW: corrected distance.
- `time_pluse_a`, in, PW: echo pulse width.
- `frame_start`, in, 1: one-cycle strobe at the start of a new scan; flushes history.
- `filter_en`, in, 1: 1 = median active, 0 = bypass. Sampled at `ad_en`.
- `MIN_DIST`, in, DW: lower range limit, inclusive.
- `MAX_DIST`, in, DW: upper range limit, inclusive.
- `MIN_PULSE`, in, PW: minimum pulse width, inclusive.
- `dist_en`, out, 1: one-cycle strobe; the output point is valid.
- `dist_out`, out, DW: filtered distance. 0 = invalid point.
- `pulse_out`, out, PW: pulse width of the emitted centre point. Never filtered.
- `err_overrun`, out, 1: sticky flag. Cleared only by reset.

## Operation
- **Qualify:** a sample is invalid if any of these holds: `ad_distance < MIN_DIST`, `ad_distance > MAX_DIST`, or `time_pluse_a < MIN_PULSE`. An invalid sample's distance is replaced by 0 and it carries an invalid bit. Its pulse is kept.
- **History:** registers `prev`, `cur` (distance, pulse, valid) and `cnt` (0..2), the number of held samples in the frame.
- **New sample x, `filter_en`=1:**
  - `cnt`=0: `cur`←x, `cnt`←1, no emission.
  - `cnt`≥1: emit the centre `cur`, then `prev`←`cur`, `cur`←x, `cnt`←2.
- **Centre value rule:**
  - `cur` invalid → 0.
  - Else, if `cnt`=2 and `prev` and x are both valid → median(`prev`,`cur`,x).
  - Else → `cur` unchanged (edge pass-through).
- **Bypass, `filter_en`=0:** emit x itself, qualified, with the same latency. Clear history (`cnt`←0).
- **Flush (`frame_start`):** if `cnt`≥1, emit `cur` as pass-through (0 if invalid). Then `cnt`←0.
- **Median:** unsigned compare. Ties resolve to the lower-index operand. Result is always one of the three inputs.
- **FSM states:**
  - IDLE: on `frame_start` → FLUSH; on `ad_en` → QUAL. If both arrive in the same cycle, FLUSH runs first and the latched sample then enters QUAL.
  - QUAL: register the qualified sample → CMP.
  - CMP: register the three comparator results → SEL.
  - SEL: drive outputs, shift history → IDLE.
  - FLUSH: drive outputs if `cnt`≥1, clear history → QUAL if a sample is pending, else IDLE.
- **Overrun:** `ad_en` outside IDLE and not already latched → the sample is dropped and `err_overrun`←1. A second `frame_start` during FLUSH is ignored (no error).

## Timing
- **Reset values:** `dist_en`=0, `dist_out`=0, `pulse_out`=0, `err_overrun`=0, `cnt`=0, FSM=IDLE.
- **Latency:** `ad_en` at cycle T → `dist_en` at T+3, carrying the previous centre (filter) or x (bypass).
- **Flush:** `frame_start` at T → `dist_en` at T+1. If flush and sample coincide, the sample's output lands at T+4.
- **Throughput:** one point per 4 cycles (5 when coinciding with a flush). The upstream stage produces at most one point per 6 cycles, so there is margin.
- `dist_out` and `pulse_out` hold their value between strobes.
- Reset asserted mid-operation: all state cleared immediately, no partial output.

## Structure
- **Shared package:** `DIST_INVALID`=0, FSM state encodings, default `DW`/`PW`.
- **Sub-module:** `median3_u16`, a combinational 3-input unsigned median with the tie rule above. Instantiated once; CMP registers its select outputs.

## Test plan
- **Median:** frame_start, then samples 1000, 1500, 1010, 1020 (all valid, limits 100..60000, `MIN_PULSE`=5, pulses 20), then frame_start → outputs 1000 (edge), 1010, 1020, 1020 (flush).
- **Invalid centre:** samples 1000, 50, 1000 → outputs 1000, 0 (out of range); `pulse_out` = the pulse of the 50 sample.
- **Invalid neighbour:** samples 1000, 1200, 1000 with pulse 3 on the last → outputs 1000, 1200 (pass-through), then 0 on flush.
- **Bypass:** `filter_en`=0, samples 700, 800 → outputs 700 at T+3 and 800 at T'+3; a flush emits nothing.
- **Simultaneous events:** `frame_start` and `ad_en` (900) in the same cycle with `cnt`=1 (held 400) → 400 at T+1; 900 is held and emerges after the next sample or flush.
- **Overrun:** a second `ad_en` 2 cycles after the first → sample dropped, `err_overrun`=1 and stays 1; reset mid-SEL → all outputs 0 next cycle.

Source files
------------

// File: rtl/distance_median_filter_pkg.sv
// Shared constants for the distance median filter: default widths, the invalid
// distance marker and the FSM state encodings.
package distance_median_filter_pkg;

    localparam int DW_DEF       = 16;
    localparam int PW_DEF       = 12;
    localparam int DIST_INVALID = 0;

    typedef logic [1:0] hist_cnt_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_QUAL  = 3'd1;
    localparam logic [2:0] ST_CMP   = 3'd2;
    localparam logic [2:0] ST_SEL   = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

endpackage

// File: rtl/median3_u16.sv
// Combinational 3-input unsigned median; returns a one-hot select of the median
// operand, preferring the lowest-index operand when values tie.
module median3_u16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [2:0]   sel
);

    logic a_med;
    logic b_med;

    assign a_med = ((a >= b) && (a <= c)) || ((a <= b) && (a >= c));
    assign b_med = ((b >= a) && (b <= c)) || ((b <= a) && (b >= c));

    assign sel[0] = a_med;
    assign sel[1] = b_med && !a_med;
    assign sel[2] = !a_med && !b_med;

endmodule

// File: rtl/distance_median_filter.sv
// Range/pulse qualification plus a 3-tap median over angularly adjacent points
// of one scan frame; one output point per input point, delayed by one point.
module distance_median_filter
    import distance_median_filter_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ad_en,
    input  logic [DW-1:0] ad_distance,
    input  logic [PW-1:0] time_pluse_a,
    input  logic          frame_start,
    input  logic          filter_en,
    input  logic [DW-1:0] MIN_DIST,
    input  logic [DW-1:0] MAX_DIST,
    input  logic [PW-1:0] MIN_PULSE,
    output logic          dist_en,
    output logic [DW-1:0] dist_out,
    output logic [PW-1:0] pulse_out,
    output logic          err_overrun
);

    // Handshake: ad_en, frame_start and dist_en are single-cycle valid strobes
    // with no ready/backpressure; a point is transferred in the cycle its strobe
    // is high, and dist_out/pulse_out hold their last value between strobes.

    logic [2:0]    state;
    hist_cnt_t     cnt;
    logic          smp_pend;
    logic          flush_pend;

    logic [DW-1:0] raw_dist;
    logic [PW-1:0] raw_pulse;
    logic          raw_byp;
    logic          raw_valid;

    logic [DW-1:0] x_dist;
    logic [PW-1:0] x_pulse;
    logic          x_valid;
    logic          x_byp;

    logic [DW-1:0] prev_dist;
    logic          prev_valid;
    logic [DW-1:0] cur_dist;
    logic [PW-1:0] cur_pulse;
    logic          cur_valid;

    logic [2:0]    med_sel;
    logic [2:0]    sel_q;
    logic [DW-1:0] med_dist;
    logic [DW-1:0] centre_dist;

    assign raw_valid = (raw_dist >= MIN_DIST) && (raw_dist <= MAX_DIST) &&
                       (raw_pulse >= MIN_PULSE);

    median3_u16 #(.W(DW)) u_median (
        .a   (prev_dist),
        .b   (cur_dist),
        .c   (x_dist),
        .sel (med_sel)
    );

    always_comb begin
        med_dist = x_dist;
        if (sel_q[0]) begin
            med_dist = prev_dist;
        end else if (sel_q[1]) begin
            med_dist = cur_dist;
        end
    end

    // The median is only trusted when both neighbours are real points.
    always_comb begin
        centre_dist = cur_dist;
        if (!cur_valid) begin
            centre_dist = DW'(DIST_INVALID);
        end else if ((cnt == 2'd2) && prev_valid && x_valid) begin
            centre_dist = med_dist;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= 2'd0;
            smp_pend    <= 1'b0;
            flush_pend  <= 1'b0;
            raw_dist    <= '0;
            raw_pulse   <= '0;
            raw_byp     <= 1'b0;
            x_dist      <= '0;
            x_pulse     <= '0;
            x_valid     <= 1'b0;
            x_byp       <= 1'b0;
            prev_dist   <= '0;
            prev_valid  <= 1'b0;
            cur_dist    <= '0;
            cur_pulse   <= '0;
            cur_valid   <= 1'b0;
            sel_q       <= '0;
            dist_en     <= 1'b0;
            dist_out    <= '0;
            pulse_out   <= '0;
            err_overrun <= 1'b0;
        end else begin
            dist_en <= 1'b0;
            if (ad_en && (state != ST_IDLE)) begin
                err_overrun <= 1'b1;
            end
            // A frame boundary seen mid-point is replayed once the point is out.
            if (frame_start && (state inside {ST_QUAL, ST_CMP, ST_SEL})) begin
                flush_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (ad_en) begin
                        raw_dist  <= ad_distance;
                        raw_pulse <= time_pluse_a;
                        raw_byp   <= !filter_en;
                    end
                    if (frame_start || flush_pend) begin
                        flush_pend <= 1'b0;
                        smp_pend   <= ad_en;
                        state      <= ST_FLUSH;
                    end else if (ad_en) begin
                        state <= ST_QUAL;
                    end
                end
                ST_QUAL: begin
                    x_dist  <= raw_valid ? raw_dist : DW'(DIST_INVALID);
                    x_pulse <= raw_pulse;
                    x_valid <= raw_valid;
                    x_byp   <= raw_byp;
                    state   <= ST_CMP;
                end
                ST_CMP: begin
                    sel_q <= med_sel;
                    state <= ST_SEL;
                end
                ST_SEL: begin
                    if (x_byp) begin
                        dist_en   <= 1'b1;
                        dist_out  <= x_dist;
                        pulse_out <= x_pulse;
                        cnt       <= 2'd0;
                    end else if (cnt == 2'd0) begin
                        cur_dist  <= x_dist;
                        cur_pulse <= x_pulse;
                        cur_valid <= x_valid;
                        cnt       <= 2'd1;
                    end else begin
                        dist_en    <= 1'b1;
                        dist_out   <= centre_dist;
                        pulse_out  <= cur_pulse;
                        prev_dist  <= cur_dist;
                        prev_valid <= cur_valid;
                        cur_dist   <= x_dist;
                        cur_pulse  <= x_pulse;
                        cur_valid  <= x_valid;
                        cnt        <= 2'd2;
                    end
                    state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (cnt != 2'd0) begin
                        dist_en   <= 1'b1;
                        dist_out  <= cur_valid ? cur_dist : DW'(DIST_INVALID);
                        pulse_out <= cur_pulse;
                    end
                    cnt      <= 2'd0;
                    smp_pend <= 1'b0;
                    state    <= smp_pend ? ST_QUAL : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_distance_median_filter.sv
// Bench for distance_median_filter: directed vector table, randomized points
// against a queue-based reference model, overrun and mid-pipeline reset.
module tb_distance_median_filter;

  localparam int DW = 16;
  localparam int PW = 12;
  localparam int W  = DW + PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ad_en;
  logic [DW-1:0] ad_distance;
  logic [PW-1:0] time_pluse_a;
  logic          frame_start;
  logic          filter_en;
  logic [DW-1:0] MIN_DIST;
  logic [DW-1:0] MAX_DIST;
  logic [PW-1:0] MIN_PULSE;
  logic          dist_en;
  logic [DW-1:0] dist_out;
  logic [PW-1:0] pulse_out;
  logic          err_overrun;

  distance_median_filter #(.DW(DW), .PW(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ad_en        (ad_en),
    .ad_distance  (ad_distance),
    .time_pluse_a (time_pluse_a),
    .frame_start  (frame_start),
    .filter_en    (filter_en),
    .MIN_DIST     (MIN_DIST),
    .MAX_DIST     (MAX_DIST),
    .MIN_PULSE    (MIN_PULSE),
    .dist_en      (dist_en),
    .dist_out     (dist_out),
    .pulse_out    (pulse_out),
    .err_overrun  (err_overrun)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int in_cyc;
  int last_out_cyc;
  int min_d, max_d, min_p;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  typedef struct {
    int d;
    int p;
    bit v;
  } pt_t;
  pt_t hist[$];

  typedef struct {
    bit fs;
    bit en;
    int d;
    int p;
    bit fe;
    bit emit;
    int ed;
    int ep;
    int lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input int p);
    exp_q.push_back({DW'(d), PW'(p)});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && dist_en === 1'b1) begin
      last_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got dist %0d pulse %0d, expected no strobe",
                 dist_out, pulse_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("dist_out", dist_out, mon_e[W-1:PW]);
        check("pulse_out", pulse_out, mon_e[PW-1:0]);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit qual_ok(input int d, input int p);
    return (d >= min_d) && (d <= max_d) && (p >= min_p);
  endfunction

  task automatic model_flush();
    if (hist.size() > 0) begin
      push_exp(hist[hist.size()-1].v ? hist[hist.size()-1].d : 0, hist[hist.size()-1].p);
    end
    hist.delete();
  endtask

  task automatic model_sample(input int d, input int p, input bit fe);
    pt_t x;
    pt_t c;
    int  trio[$];
    int  o;
    x.v = qual_ok(d, p);
    x.d = x.v ? d : 0;
    x.p = p;
    if (!fe) begin
      push_exp(x.d, x.p);
      hist.delete();
    end else if (hist.size() == 0) begin
      hist.push_back(x);
    end else begin
      c = hist[hist.size()-1];
      if (!c.v) begin
        o = 0;
      end else if (hist.size() == 2 && hist[0].v && x.v) begin
        trio = '{hist[0].d, c.d, x.d};
        trio.sort();
        o = trio[1];
      end else begin
        o = c.d;
      end
      push_exp(o, c.p);
      if (hist.size() == 2) void'(hist.pop_front());
      hist.push_back(x);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_limits(input int lo, input int hi, input int pmin);
    min_d = lo;
    max_d = hi;
    min_p = pmin;
    MIN_DIST  = DW'(lo);
    MAX_DIST  = DW'(hi);
    MIN_PULSE = PW'(pmin);
  endtask

  task automatic drive_event(input bit fs, input bit en, input int d, input int p, input bit fe);
    frame_start  = fs;
    ad_en        = en;
    ad_distance  = DW'(d);
    time_pluse_a = PW'(p);
    filter_en    = fe;
    @(posedge clk);
    #1;
    in_cyc      = cyc;
    frame_start = 1'b0;
    ad_en       = 1'b0;
  endtask

  function automatic void add(input bit fs, input bit en, input int d, input int p, input bit fe,
                              input bit emit, input int ed, input int ep, input int lat);
    vec_t v;
    v.fs = fs; v.en = en; v.d = d; v.p = p; v.fe = fe;
    v.emit = emit; v.ed = ed; v.ep = ep; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // ---------------- test sequence ----------------
  int r, d, p, last_d;
  bit fs, en, fe;

  initial begin
    rst = 1'b0;
    ad_en = 1'b0;
    frame_start = 1'b0;
    filter_en = 1'b1;
    ad_distance = '0;
    time_pluse_a = '0;
    set_limits(100, 60000, 5);
    last_out_cyc = -1;
    idle(3);
    rst = 1'b1;
    idle(1);

    check("reset_dist_en", dist_en, 0);
    check("reset_dist_out", dist_out, 0);
    check("reset_pulse_out", pulse_out, 0);
    check("reset_err_overrun", err_overrun, 0);

    //  fs en  dist  pulse fe   emit  exp_d exp_p lat
    add(1, 0, 0,     0,  1,   0, 0,     0,  0);   // median frame
    add(0, 1, 1000,  20, 1,   0, 0,     0,  0);
    add(0, 1, 1500,  20, 1,   1, 1000,  20, 3);
    add(0, 1, 1010,  20, 1,   1, 1010,  20, 3);
    add(0, 1, 1020,  20, 1,   1, 1020,  20, 3);
    add(1, 0, 0,     0,  1,   1, 1020,  20, 1);
    add(0, 1, 1000,  21, 1,   0, 0,     0,  0);   // invalid centre
    add(0, 1, 50,    22, 1,   1, 1000,  21, 3);
    add(0, 1, 1000,  23, 1,   1, 0,     22, 3);
    add(1, 0, 0,     0,  1,   1, 1000,  23, 1);
    add(0, 1, 1000,  20, 1,   0, 0,     0,  0);   // invalid neighbour
    add(0, 1, 1200,  20, 1,   1, 1000,  20, 3);
    add(0, 1, 1000,  3,  1,   1, 1200,  20, 3);
    add(1, 0, 0,     0,  1,   1, 0,     3,  1);
    add(0, 1, 700,   30, 0,   1, 700,   30, 3);   // bypass
    add(0, 1, 800,   31, 0,   1, 800,   31, 3);
    add(1, 0, 0,     0,  0,   0, 0,     0,  0);
    add(0, 1, 65000, 32, 0,   1, 0,     32, 3);
    add(0, 1, 400,   40, 1,   0, 0,     0,  0);   // flush + sample together
    add(1, 1, 900,   41, 1,   1, 400,   40, 1);
    add(1, 0, 0,     0,  1,   1, 900,   41, 1);
    add(0, 1, 100,   5,  1,   0, 0,     0,  0);   // inclusive limits
    add(0, 1, 60000, 5,  1,   1, 100,   5,  3);
    add(0, 1, 99,    5,  1,   1, 60000, 5,  3);
    add(0, 1, 60001, 5,  1,   1, 0,     5,  3);
    add(1, 0, 0,     0,  1,   1, 0,     5,  1);
    add(0, 1, 500,   9,  1,   0, 0,     0,  0);   // ties
    add(0, 1, 500,   10, 1,   1, 500,   9,  3);
    add(0, 1, 300,   11, 1,   1, 500,   10, 3);
    add(1, 0, 0,     0,  1,   1, 300,   11, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].emit) push_exp(vecs[i].ed, vecs[i].ep);
      last_out_cyc = -1;
      drive_event(vecs[i].fs, vecs[i].en, vecs[i].d, vecs[i].p, vecs[i].fe);
      idle(6);
      if (vecs[i].emit) begin
        check($sformatf("latency[%0d]", i), last_out_cyc - in_cyc, vecs[i].lat);
        check($sformatf("hold[%0d]", i), dist_out, vecs[i].ed);
      end else begin
        check($sformatf("no_output[%0d]", i), last_out_cyc, -1);
      end
    end

    // randomized points against the reference model
    set_limits(200, 40000, 10);
    last_d = 1000;
    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 9);
      fs = (r <= 1);
      en = (r != 0);
      case ($urandom_range(0, 4))
        0: d = $urandom_range(0, 65535);
        1: d = $urandom_range(min_d - 2, min_d + 2);
        2: d = $urandom_range(max_d - 2, max_d + 2);
        3: d = last_d;
        default: d = $urandom_range(min_d, max_d);
      endcase
      p  = $urandom_range(0, 40);
      fe = ($urandom_range(0, 7) != 0);
      if (en) last_d = d;
      if (fs) model_flush();
      if (en) model_sample(d, p, fe);
      drive_event(fs, en, d, p, fe);
      idle($urandom_range(5, 8));
    end
    model_flush();
    drive_event(1, 0, 0, 0, 1);
    idle(6);
    check("no_overrun_yet", err_overrun, 0);

    // overrun: a second point two cycles after the first is dropped
    model_sample(1000, 20, 1);
    drive_event(0, 1, 1000, 20, 1);
    idle(1);
    drive_event(0, 1, 2000, 20, 1);
    idle(6);
    check("err_overrun_set", err_overrun, 1);
    model_flush();
    drive_event(1, 0, 0, 0, 1);
    idle(6);
    check("err_overrun_sticky", err_overrun, 1);

    // reset while the point sits in the output stage
    drive_event(0, 1, 555, 25, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    @(negedge clk);
    check("midreset_dist_en", dist_en, 0);
    check("midreset_dist_out", dist_out, 0);
    check("midreset_pulse_out", pulse_out, 0);
    check("midreset_err_overrun", err_overrun, 0);
    idle(2);
    rst = 1'b1;
    idle(2);

    // history must start empty after reset
    model_sample(1234, 20, 1);
    drive_event(0, 1, 1234, 20, 1);
    idle(6);
    model_flush();
    drive_event(1, 0, 0, 0, 1);
    idle(10);

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
